// File: rtl/alu_reg.sv
// Single-cycle execute unit: eight-operation unsigned ALU followed by a
// registered result stage carrying out, carry, zero and a valid strobe.
module alu_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    // Result packed as {carry, value}; SUB's extra bit is the borrow (A < B).
    function automatic logic [WIDTH:0] alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input op_e              op
    );
        logic [WIDTH:0] res;
        res = '0;
        case (op)
            OP_ADD: res = {1'b0, a} + {1'b0, b};
            OP_SUB: res = {1'b0, a} - {1'b0, b};
            OP_AND: res = {1'b0, a & b};
            OP_OR:  res = {1'b0, a | b};
            OP_XOR: res = {1'b0, a ^ b};
            OP_NOT: res = {1'b0, ~a};
            OP_SHL: res = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
            OP_SHR: res = {a[0], 1'b0, a[WIDTH-1:1]};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    logic [WIDTH:0]   w_res_p0;
    logic [WIDTH-1:0] r_out_p1;
    logic             r_carry_p1;
    logic             r_zero_p1;
    logic             r_vld_p1;

    always_comb begin
        w_res_p0 = alu_eval(A, B, op_e'(sel));
    end

    // p0 -> p1: capture result only on accepted requests, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p1   <= '0;
            r_carry_p1 <= 1'b0;
            r_zero_p1  <= 1'b0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_out_p1   <= w_res_p0[WIDTH-1:0];
                r_carry_p1 <= w_res_p0[WIDTH];
                r_zero_p1  <= is_zero(w_res_p0[WIDTH-1:0]);
            end
        end
    end

    assign out       = r_out_p1;
    assign carry     = r_carry_p1;
    assign zero      = r_zero_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_alu_reg.sv
// Directed bench for alu_reg (WIDTH=4) with hand-computed expected values.
module tb_alu_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] sel;
    logic [3:0] out;
    logic       carry;
    logic       zero;
    logic       out_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .out       (out),
        .carry     (carry),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] e_out,
                         input logic e_c, input logic e_z, input logic e_v);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {out, carry, zero, out_valid};
        exp = {e_out, e_c, e_z, e_v};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got out=%b c=%b z=%b v=%b, want out=%b c=%b z=%b v=%b",
                   tag, out, carry, zero, out_valid, e_out, e_c, e_z, e_v);
        end
    endtask

    // Present inputs, then sample 1 time unit after the next rising edge
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] s);
        in_valid = v;
        A        = a;
        B        = b;
        sel      = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        A        = 4'b0000;
        B        = 4'b0000;
        sel      = 3'b000;

        #3 rst_n = 1'b0;
        #1 check("rst_async", 4'b0000, 0, 0, 0);
        @(posedge clk); #1;
        check("rst_held", 4'b0000, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        step(0, 4'b1111, 4'b1111, 3'b000);
        check("post_rst_idle1", 4'b0000, 0, 0, 0);
        step(0, 4'b1010, 4'b0110, 3'b110);
        check("post_rst_idle2", 4'b0000, 0, 0, 0);

        step(1, 4'b0101, 4'b0011, 3'b000); check("sweep_add", 4'b1000, 0, 0, 1);
        step(1, 4'b0101, 4'b0011, 3'b001); check("sweep_sub", 4'b0010, 0, 0, 1);
        step(1, 4'b0101, 4'b0011, 3'b010); check("sweep_and", 4'b0001, 0, 0, 1);
        step(1, 4'b0101, 4'b0011, 3'b011); check("sweep_or",  4'b0111, 0, 0, 1);
        step(1, 4'b0101, 4'b0011, 3'b100); check("sweep_xor", 4'b0110, 0, 0, 1);
        step(1, 4'b0101, 4'b0011, 3'b101); check("sweep_not", 4'b1010, 0, 0, 1);
        step(1, 4'b0101, 4'b0011, 3'b110); check("sweep_shl", 4'b1010, 0, 0, 1);
        step(1, 4'b0101, 4'b0011, 3'b111); check("sweep_shr", 4'b0010, 1, 0, 1);

        step(1, 4'b1111, 4'b0001, 3'b000); check("add_wrap",  4'b0000, 1, 1, 1);
        step(1, 4'b0011, 4'b0011, 3'b001); check("sub_zero",  4'b0000, 0, 1, 1);
        step(1, 4'b0011, 4'b0101, 3'b001); check("sub_borrow", 4'b1110, 1, 0, 1);
        step(1, 4'b1001, 4'b0000, 3'b110); check("shl_out",   4'b0010, 1, 0, 1);
        step(1, 4'b1111, 4'b0000, 3'b101); check("not_zero",  4'b0000, 0, 1, 1);

        step(1, 4'b0101, 4'b0011, 3'b000); check("hold_req",   4'b1000, 0, 0, 1);
        step(0, 4'b1111, 4'b0001, 3'b001); check("hold_idle1", 4'b1000, 0, 0, 0);
        step(0, 4'b0000, 4'b1110, 3'b111); check("hold_idle2", 4'b1000, 0, 0, 0);

        step(1, 4'b0101, 4'b0011, 3'b000); check("mid_req1", 4'b1000, 0, 0, 1);
        step(1, 4'b0011, 4'b0101, 3'b001); check("mid_req2", 4'b1110, 1, 0, 1);
        in_valid = 1'b1;
        A        = 4'b1111;
        B        = 4'b0001;
        sel      = 3'b000;
        #2 rst_n = 1'b0;
        #1 check("mid_rst_async", 4'b0000, 0, 0, 0);
        @(posedge clk); #1;
        check("mid_rst_discard", 4'b0000, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        in_valid = 1'b0;
        #1 check("mid_rst_release", 4'b0000, 0, 0, 0);
        step(1, 4'b0110, 4'b0011, 3'b100); check("after_rst_xor", 4'b0101, 0, 0, 1);
        step(0, 4'b0000, 4'b0000, 3'b000); check("after_rst_idle", 4'b0101, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
